// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump/call/return with a LIFO
// return stack, plus RUN/HALT/FAULT control. pc is always a register.
module pc_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int OFF_W    = 8,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         branch,
  input  logic                         jmp,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt_req,
  input  logic                         resume,
  input  logic [OFF_W-1:0]             offset,
  input  logic [ADDR_W-1:0]            target,
  output logic [ADDR_W-1:0]            pc,
  output logic [1:0]                   state,
  output logic [$clog2(DEPTH+1)-1:0]   depth_used,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, FAULT = 2'b10} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc, off_ext;
  logic [DW-1:0]       depth_q;
  logic                ovf_q, unf_q;
  logic                push, pop, set_ovf, set_unf;
  logic                empty, full;
  logic [AW-1:0]       top_idx, push_idx;
  logic [ADDR_W-1:0]   stack_mem [DEPTH];

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DW'(DEPTH));
  assign top_idx  = AW'(depth_q - DW'(1));
  assign push_idx = AW'(depth_q);
  assign pc_inc   = pc_q + ADDR_W'(1);
  // Size cast of a signed value sign-extends the offset to the pc width.
  assign off_ext  = ADDR_W'($signed(offset));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // ret outranks call, so a full stack only faults when ret is absent.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        RUN: begin
          if (halt_req)                state_d = HALT;
          else if (ret && empty)       state_d = FAULT;
          else if (!ret && call && full) state_d = FAULT;
        end
        HALT:    if (resume) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (en && state_q == RUN && !halt_req) begin
      if (ret) begin
        if (empty) set_unf = 1'b1;
        else begin
          pop  = 1'b1;
          pc_d = stack_mem[top_idx];
        end
      end else if (call) begin
        if (full) set_ovf = 1'b1;
        else begin
          push = 1'b1;
          pc_d = target;
        end
      end else if (jmp)    pc_d = target;
      else if (branch)     pc_d = pc_inc + off_ext;
      else                 pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= ADDR_W'(RESET_PC);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (push)     depth_q <= depth_q + DW'(1);
      else if (pop) depth_q <= depth_q - DW'(1);
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  // Stack contents need no reset; only the occupancy count is architectural.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= pc_inc;
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign depth_used = depth_q;
  assign stack_ovf  = ovf_q;
  assign stack_unf  = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 12, meaning program-counter width in bits.
REQ-002 The block SHALL provide parameter OFF_W, default 8, meaning signed branch-offset width, with OFF_W <= ADDR_W.
REQ-003 The block SHALL provide parameter DEPTH, default 8, meaning return-stack entries (>= 2).
REQ-004 The block SHALL provide parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-006 The block SHALL have port clk  input  1  rising-edge clock.
REQ-007 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-008 The block SHALL have port en  input  1  advance enable; 0 = stall, no state change.
REQ-009 The block SHALL have port branch  input  1  taken-branch request.
REQ-010 The block SHALL have port jmp  input  1  absolute jump request.
REQ-011 The block SHALL have port call  input  1  push pc+1, then jump to target.
REQ-012 The block SHALL have port ret  input  1  pop the return address into pc.
REQ-013 The block SHALL have port halt_req  input  1  enter HALT.
REQ-014 The block SHALL have port resume  input  1  leave HALT.
REQ-015 The block SHALL have port offset  input  OFF_W  two's-complement branch offset.
REQ-016 The block SHALL have port target  input  ADDR_W  absolute jump/call address.
REQ-017 The block SHALL have port pc  output  ADDR_W  current program counter (registered).
REQ-018 The block SHALL have port state  output  2  00 RUN, 01 HALT, 10 FAULT.
REQ-019 The block SHALL have port depth_used  output  $clog2(DEPTH+1)  number of occupied stack entries.
REQ-020 The block SHALL have port stack_ovf  output  1  sticky flag: call attempted with the stack full.
REQ-021 The block SHALL have port stack_unf  output  1  sticky flag: ret attempted with the stack empty.

Function
REQ-022 The block SHALL update all state only on the rising edge of clk, and only when en=1 (except reset).
REQ-023 In RUN, the block SHALL select the next PC by priority: halt_req > ret > call > jmp > branch > sequential; lower-priority requests in the same cycle SHALL be ignored.
REQ-024 Sequential operation SHALL set pc <= pc+1, modulo 2^ADDR_W.
REQ-025 Branch SHALL set pc <= pc + 1 + sign_extend(offset), modulo 2^ADDR_W, so wrap-around in both directions is legal.
REQ-026 Jmp SHALL set pc <= target.
REQ-027 Call with depth_used < DEPTH SHALL write pc+1 (mod 2^ADDR_W) to the top of the stack, increment depth_used, and set pc <= target, all in the same cycle.
REQ-028 Ret with depth_used > 0 SHALL set pc <= the top entry and decrement depth_used; the top entry is the most recently pushed (LIFO).
REQ-029 Call with depth_used = DEPTH SHALL hold pc and the stack unchanged, set stack_ovf=1, and move to FAULT.
REQ-030 Ret with depth_used = 0 SHALL hold pc unchanged, set stack_unf=1, and move to FAULT.
REQ-031 Halt_req in RUN SHALL hold pc and the stack, and move to HALT on the next edge.
REQ-032 In HALT, resume=1 SHALL move to RUN with pc held; the first advance SHALL occur on the following enabled edge. All other requests SHALL be ignored in HALT.
REQ-033 FAULT SHALL be exited only by reset; pc, the stack and the flags SHALL hold.
REQ-034 The latency from any request to the visible pc SHALL be 1 enabled clock; pc SHALL have no combinational path from the inputs.
REQ-035 With en=0, all inputs including halt_req and resume SHALL be ignored.

Reset
REQ-036 While rst=0, the block SHALL asynchronously force pc=RESET_PC, state=RUN, depth_used=0, stack_ovf=0 and stack_unf=0; stack contents are don't-care.
REQ-037 Reset asserted mid-call or mid-ret SHALL discard the operation in progress; the first enabled edge after rst rises SHALL perform normal RUN sequencing from RESET_PC.

Verification
REQ-038 Reset, then 3 enabled edges with no requests -> pc = 0,1,2,3; state=00.
REQ-039 At pc=0x010, branch with offset=0xF0 (-16) -> pc=0x001; at pc=0xFFF, sequential -> pc=0x000.
REQ-040 At pc=0x020, call target=0x100; then jmp 0x200; then ret -> pc sequence 0x100, 0x200, 0x021; depth_used 1, 1, 0.
REQ-041 Perform 8 nested calls, then a 9th call -> stack_ovf=1, state=10, pc unchanged; subsequent requests are ignored until reset.
REQ-042 Ret on an empty stack -> stack_unf=1, state=10; with ret and call in the same cycle and depth_used=2 -> ret wins and depth_used becomes 1.
REQ-043 Assert halt_req together with jmp -> state=01, pc held; en=0 with resume=1 -> no change; en=1 with resume=1 -> RUN; the next edge -> pc+1.
